// File: rtl/mapped_wt_cache_pkg.sv
// rtl/mapped_wt_cache_pkg.sv - shared state encoding and default address map for the word cache
package mapped_wt_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_WDONE
    } state_t;

    localparam logic [31:0] DEF_CACHE_BASE  = 32'h0000_0000;
    localparam logic [31:0] DEF_CACHE_LIMIT = 32'h0FFF_FFFF;

endpackage

// File: rtl/mapped_wt_cache_memory_map.sv
// rtl/mapped_wt_cache_memory_map.sv - combinational decoder flagging addresses inside the cacheable window
module memory_map
    import mapped_wt_cache_pkg::*;
#(
    parameter logic [31:0] BASE  = DEF_CACHE_BASE,
    parameter logic [31:0] LIMIT = DEF_CACHE_LIMIT
) (
    input  logic [31:0] addr_i,
    output logic        cacheable_o
);

    // Offset form keeps a single unsigned compare and stays correct when BASE is zero.
    assign cacheable_o = ((addr_i - BASE) <= (LIMIT - BASE));

endmodule

// File: rtl/mapped_wt_cache.sv
// rtl/mapped_wt_cache.sv - direct-mapped write-through no-write-allocate word cache
module mapped_wt_cache
    import mapped_wt_cache_pkg::*;
#(
    parameter int          WORD_SIZE   = 32,
    parameter int          INDEX_BITS  = 4,
    parameter logic [31:0] CACHE_BASE  = DEF_CACHE_BASE,
    parameter logic [31:0] CACHE_LIMIT = DEF_CACHE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic                 re,
    input  logic                 wr,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 cacheable,
    output logic                 cache_miss_stall,
    output logic [31:0]          ext_addr,
    output logic                 ext_re,
    output logic                 ext_wr,
    output logic [WORD_SIZE-1:0] ext_data_out,
    input  logic [WORD_SIZE-1:0] ext_data_in,
    input  logic                 ext_ack
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    state_t                 state_q;
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [WORD_SIZE-1:0]   data_q [LINES];
    logic [31:0]            lat_addr_q;
    logic [WORD_SIZE-1:0]   lat_data_q;
    logic                   ext_re_q;
    logic                   ext_wr_q;

    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_W-1:0]       tag;
    logic [INDEX_BITS-1:0]  lat_idx;
    logic [TAG_W-1:0]       lat_tag;
    logic                   req;
    logic                   hit;
    logic                   lat_hit;

    memory_map #(
        .BASE  (CACHE_BASE),
        .LIMIT (CACHE_LIMIT)
    ) u_map (
        .addr_i      (addr),
        .cacheable_o (cacheable)
    );

    assign idx     = addr[2 +: INDEX_BITS];
    assign tag     = addr[31 : 2+INDEX_BITS];
    assign lat_idx = lat_addr_q[2 +: INDEX_BITS];
    assign lat_tag = lat_addr_q[31 : 2+INDEX_BITS];
    assign req     = cacheable && (re || wr);
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    assign ext_addr     = lat_addr_q;
    assign ext_data_out = lat_data_q;
    assign ext_re       = ext_re_q;
    assign ext_wr       = ext_wr_q;

    always_comb begin
        cache_miss_stall = 1'b0;
        data_out         = '0;
        case (state_q)
            ST_IDLE: begin
                cache_miss_stall = req && (wr || !hit);
                if (req && !wr && hit) begin
                    data_out = data_q[idx];
                end
            end
            ST_FILL, ST_WRITE: cache_miss_stall = 1'b1;
            default: cache_miss_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            valid_q    <= '0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            ext_re_q   <= 1'b0;
            ext_wr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req && wr) begin
                        lat_addr_q <= {addr[31:2], 2'b00};
                        lat_data_q <= data_in;
                        ext_wr_q   <= 1'b1;
                        state_q    <= ST_WRITE;
                    end else if (req && !hit) begin
                        lat_addr_q <= {addr[31:2], 2'b00};
                        ext_re_q   <= 1'b1;
                        state_q    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (ext_ack) begin
                        valid_q[lat_idx] <= 1'b1;
                        tag_q[lat_idx]   <= lat_tag;
                        data_q[lat_idx]  <= ext_data_in;
                        ext_re_q         <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    // Write-through: refresh a resident line, never allocate a new one.
                    if (ext_ack) begin
                        if (lat_hit) begin
                            data_q[lat_idx] <= lat_data_q;
                        end
                        ext_wr_q <= 1'b0;
                        state_q  <= ST_WDONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mapped_wt_cache.sv
// tb/tb_mapped_wt_cache.sv - scoreboard bench for the mapped write-through cache
module tb_mapped_wt_cache;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
    } ext_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        re;
    logic        wr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        cacheable;
    logic        cache_miss_stall;
    logic [31:0] ext_addr;
    logic        ext_re;
    logic        ext_wr;
    logic [31:0] ext_data_out;
    logic [31:0] ext_data_in = '0;
    logic        ext_ack = 1'b0;

    int tests = 0;
    int fails = 0;
    int ack_delay = 0;

    logic [31:0] rd_q[$];
    ext_t        ext_q[$];

    mapped_wt_cache dut (
        .clk              (clk),
        .rst              (rst),
        .addr             (addr),
        .re               (re),
        .wr               (wr),
        .data_in          (data_in),
        .data_out         (data_out),
        .cacheable        (cacheable),
        .cache_miss_stall (cache_miss_stall),
        .ext_addr         (ext_addr),
        .ext_re           (ext_re),
        .ext_wr           (ext_wr),
        .ext_data_out     (ext_data_out),
        .ext_data_in      (ext_data_in),
        .ext_ack          (ext_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // External memory: acks each strobe after ack_delay cycles.
    initial begin : ext_mem
        bit [31:0] mem [bit [31:0]];
        int        wait_cnt;
        wait_cnt = 0;
        mem[32'h10] = 32'hDEAD_BEEF;
        mem[32'h50] = 32'hCAFE_F00D;
        mem[32'h60] = 32'h600D_600D;
        mem[32'h24] = 32'h2424_2424;
        forever begin
            @(negedge clk);
            if (rst || !(ext_re || ext_wr) || ext_ack) begin
                ext_ack  = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= ack_delay) begin
                ext_ack = 1'b1;
                if (ext_wr) mem[ext_addr] = ext_data_out;
                else        ext_data_in = mem.exists(ext_addr) ? mem[ext_addr] : 32'h0;
            end else begin
                wait_cnt++;
            end
        end
    end

    initial begin : monitor
        bit   prev_strobe;
        ext_t e;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if ((ext_re || ext_wr) && !prev_strobe) begin
                if (ext_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL ext_unexpected: got strobe at %h expected none", ext_addr);
                end else begin
                    e = ext_q.pop_front();
                    chk("ext_kind_wr", {31'b0, ext_wr}, {31'b0, e.w});
                    chk("ext_kind_re", {31'b0, ext_re}, {31'b0, !e.w});
                    chk("ext_addr", ext_addr, e.a);
                    if (e.w) chk("ext_data_out", ext_data_out, e.d);
                end
            end
            prev_strobe = ext_re || ext_wr;
            if (!rst && re && !wr && cacheable && !cache_miss_stall) begin
                if (rd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: got %h expected no read", data_out);
                end else begin
                    chk("rd_data", data_out, rd_q.pop_front());
                end
            end
        end
    end

    task automatic access(input logic [31:0] a, input bit w, input bit r, input logic [31:0] wd,
                          input bit ext_exp, input logic [31:0] exp_rd, input int exp_stall,
                          input string name);
        int cnt;
        bit done;
        addr    = a;
        wr      = w;
        re      = r;
        data_in = wd;
        if (ext_exp) ext_q.push_back('{w, {a[31:2], 2'b00}, wd});
        if (r && !w) rd_q.push_back(exp_rd);
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cache_miss_stall) cnt++;
            else done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got stall after 200 cycles expected release", name);
        end
        chk({name, "_stall_cycles"}, cnt, exp_stall);
        @(posedge clk);
        #1;
        re = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, cache_miss_stall}, 0);
        chk("rst_ext_re", {31'b0, ext_re}, 0);
        chk("rst_ext_wr", {31'b0, ext_wr}, 0);
        chk("rst_ext_addr", ext_addr, 0);
        chk("rst_ext_data_out", ext_data_out, 0);
        chk("rst_data_out", data_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        access(32'h10, 0, 1, 0, 1, 32'hDEAD_BEEF, 2, "rd_miss_10");
        access(32'h13, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, "rd_hit_13");
        access(32'h50, 0, 1, 0, 1, 32'hCAFE_F00D, 2, "rd_miss_50");
        access(32'h10, 0, 1, 0, 1, 32'hDEAD_BEEF, 2, "rd_refill_10");
        access(32'h10, 1, 0, 32'h1234_5678, 1, 0, 2, "wr_hit_10");
        access(32'h10, 0, 1, 0, 0, 32'h1234_5678, 0, "rd_hit_after_wr");
        access(32'h20, 1, 0, 32'h55AA_55AA, 1, 0, 2, "wr_noalloc_20");
        access(32'h20, 0, 1, 0, 1, 32'h55AA_55AA, 2, "rd_miss_20");

        addr = 32'h1000_0000;
        re   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("uc_cacheable", {31'b0, cacheable}, 0);
            chk("uc_stall", {31'b0, cache_miss_stall}, 0);
            chk("uc_data_out", data_out, 0);
        end
        @(posedge clk);
        #1 re = 1'b0;
        addr = 32'h0FFF_FFFF;
        #1 chk("limit_cacheable", {31'b0, cacheable}, 1);

        ack_delay = 5;
        access(32'h60, 0, 1, 0, 1, 32'h600D_600D, 7, "rd_slow_ack_60");
        ack_delay = 0;
        access(32'h60, 1, 1, 32'hA5A5_A5A5, 1, 0, 2, "rw_both_60");
        access(32'h60, 0, 1, 0, 0, 32'hA5A5_A5A5, 0, "rd_hit_60");

        ack_delay = 20;
        addr = 32'h24;
        re   = 1'b1;
        ext_q.push_back('{1'b0, 32'h24, 32'h0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fill_stall", {31'b0, cache_miss_stall}, 1);
        @(posedge clk);
        #1 rst = 1'b1; re = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ext_re", {31'b0, ext_re}, 0);
        chk("abort_stall", {31'b0, cache_miss_stall}, 0);
        chk("abort_ext_addr", ext_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ack_delay = 0;
        access(32'h10, 0, 1, 0, 1, 32'h1234_5678, 2, "rd_after_rst");

        repeat (3) @(posedge clk);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("ext_q_empty", ext_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
